memory_stage: RTL and testbench
===============================

# memory_stage

Pipeline MEM stage sitting directly downstream of the execute stage. It consumes the EX/MEM values (ALU result, store data, set value, next PC and control bits) and runs a variable-latency data-memory access through a request/done handshake. It stalls the upstream pipeline while the access is outstanding and registers the MEM/WB values consumed by writeback.

## Interface
- TIMEOUT, 15: maximum cycles in WAIT before the access is abandoned with an error; legal range 1..255.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- aluResult  in  16  EX result; used as memory address and as a passthrough value
- storeData  in  16  store data (EX reg2 value)
- setVal  in  16  EX set-instruction result, passed through
- nextPc  in  16  PC+2, passed through for link writes
- memEn  in  1  instruction accesses memory
- memWrt  in  1  access is a store (valid only with memEn)
- regWrt  in  1  instruction writes the register file
- regWrtSrc  in  3  writeback source select, passed through
- writeReg  in  3  destination register, passed through
- halt  in  1  halt instruction
- errIn  in  1  upstream error
- memDone  in  1  memory completes the current request this cycle
- memErr  in  1  memory error; sampled only with memDone
- memRdData  in  16  load data; valid with memDone
- memReq  out  1  access request (combinational)
- memWr  out  1  1 = write, 0 = read; valid with memReq
- memAddr  out  16  = aluResult
- memWrData  out  16  = storeData
- stall  out  1  upstream must hold its EX/MEM values this cycle (combinational)
- memDataOut  out  16  registered load data
- aluOut  out  16  registered aluResult
- setValOut  out  16  registered setVal
- nextPcOut  out  16  registered nextPc
- regWrtOut  out  1  registered register-write enable
- regWrtSrcOut  out  3  registered source select
- writeRegOut  out  3  registered destination register
- haltOut  out  1  registered halt
- err  out  1  registered error (errIn | memErr | timeout)

## Operation
- Two states: IDLE and WAIT. A 8-bit wait counter is cleared on entry to WAIT.
- IDLE, memEn=0: memReq=0 and stall=0. The MEM/WB register captures all passthrough inputs. memDataOut gets 0.
- IDLE, memEn=1, halt=0: memReq=1 and memWr=memWrt.
  - If memDone=1 in the same cycle, the access completes: no stall, capture as below.
  - If memDone=0, go to WAIT with stall=1.
- WAIT: memReq stays 1; address, data and memWr stay stable because the upstream holds its values. stall=1 until memDone.
  - On memDone: stall=0 and the MEM/WB register captures. memDataOut gets memRdData for a read, or 0 for a write. Return to IDLE.
  - Without memDone: the counter increments.
- Timeout: when the counter reaches TIMEOUT-1 without memDone, the access is abandoned. memReq drops next cycle, stall=0 that cycle, and the instruction is captured with err=1 and regWrtOut=0. Return to IDLE.
- Bubble rule: every cycle with stall=1, the MEM/WB register loads a bubble: regWrtOut=0, haltOut=0, err=0; data fields hold.
- halt=1 with memEn=1: the memory access is suppressed (memReq=0). haltOut=1 is captured next edge.
- err captured = errIn | (memDone & memErr) | timeout.
- A store never writes the register file on its own: regWrtOut simply follows regWrt.

## Timing
- Reset (asynchronous): state=IDLE, counter=0, and every registered output = 0. memReq and stall are 0 while rst=1.
- Latency:
  - Non-memory instruction: outputs valid 1 cycle after inputs.
  - Zero-wait access: 1 cycle.
  - N-wait access (memDone N cycles after first memReq): outputs valid N+1 cycles after entry, with N bubbles preceding.
- memDone while memReq=0 is ignored.
- memDone on the same edge the timeout fires: memDone wins, no error.
- rst asserted during WAIT: memReq drops immediately, and the pending access is discarded.
- Back-to-back accesses: the next request can assert in the cycle after completion.

## Test plan
- ALU op, aluResult=16'h1234, regWrt=1, writeReg=3, memEn=0 -> next cycle aluOut=16'h1234, regWrtOut=1, writeRegOut=3, stall never 1.
- Load at 16'h0040, memDone same cycle with memRdData=16'hBEEF -> no stall; next cycle memDataOut=16'hBEEF, regWrtOut=1.
- Load, memDone after 3 cycles -> stall=1 for exactly 3 cycles with regWrtOut=0 during them; memDataOut=16'hBEEF on the 4th edge; memReq held with memAddr constant throughout.
- Store addr 16'h0010, data 16'hA5A5, memDone after 1 cycle -> memWr=1, memWrData=16'hA5A5, one bubble, then memDataOut=0.
- Load with memDone never asserted, TIMEOUT=15 -> stall for 15 cycles, then err=1 and regWrtOut=0; memReq low afterwards; IDLE next.
- rst pulsed during WAIT -> memReq/stall low immediately; all outputs 0. Halt with memEn=1 -> no memReq, haltOut=1 next cycle.

Source files
------------

// File: rtl/memory_stage.sv
// Pipeline MEM stage: drives a request/done data-memory access and registers MEM/WB values.
// Latency: 1 cycle for non-memory or zero-wait accesses, N+1 cycles for an N-wait access.
// Backpressure: stall is raised combinationally while an access is outstanding; bubbles enter MEM/WB.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   aluResult/storeData/setVal/nextPc, memEn/memWrt/regWrt/regWrtSrc/writeReg/halt/errIn
//                                EX/MEM values from the execute stage
//   memReq/memWr/memAddr/memWrData, memDone/memErr/memRdData
//                                data-memory request/done handshake
//   stall                        upstream hold request
//   memDataOut/aluOut/setValOut/nextPcOut/regWrtOut/regWrtSrcOut/writeRegOut/haltOut/err
//                                registered MEM/WB values for writeback
module memory_stage #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] aluResult,
    input  logic [15:0] storeData,
    input  logic [15:0] setVal,
    input  logic [15:0] nextPc,
    input  logic        memEn,
    input  logic        memWrt,
    input  logic        regWrt,
    input  logic [2:0]  regWrtSrc,
    input  logic [2:0]  writeReg,
    input  logic        halt,
    input  logic        errIn,
    input  logic        memDone,
    input  logic        memErr,
    input  logic [15:0] memRdData,
    output logic        memReq,
    output logic        memWr,
    output logic [15:0] memAddr,
    output logic [15:0] memWrData,
    output logic        stall,
    output logic [15:0] memDataOut,
    output logic [15:0] aluOut,
    output logic [15:0] setValOut,
    output logic [15:0] nextPcOut,
    output logic        regWrtOut,
    output logic [2:0]  regWrtSrcOut,
    output logic [2:0]  writeRegOut,
    output logic        haltOut,
    output logic        err
);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] waitCnt;
    logic       reqIdle;
    logic       memAck;
    logic       timeout;

    // A halted instruction never touches memory.
    assign reqIdle = (state == ST_IDLE) && memEn && !halt;

    // Request is held through WAIT, including the timeout cycle itself, so a
    // memDone arriving on that same cycle still completes the access cleanly.
    assign memReq    = !rst && ((state == ST_WAIT) || reqIdle);
    assign memWr     = memReq && memWrt;
    assign memAddr   = aluResult;
    assign memWrData = storeData;

    assign memAck  = memReq && memDone;
    assign timeout = !rst && (state == ST_WAIT) && (waitCnt == WAIT_LAST) && !memDone;
    assign stall   = memReq && !memDone && !timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            waitCnt      <= 8'd0;
            memDataOut   <= 16'd0;
            aluOut       <= 16'd0;
            setValOut    <= 16'd0;
            nextPcOut    <= 16'd0;
            regWrtOut    <= 1'b0;
            regWrtSrcOut <= 3'd0;
            writeRegOut  <= 3'd0;
            haltOut      <= 1'b0;
            err          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (stall) begin
                        state   <= ST_WAIT;
                        waitCnt <= 8'd0;
                    end
                end
                ST_WAIT: begin
                    if (!stall) begin
                        state <= ST_IDLE;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (stall) begin
                // Bubble: kill the side-effecting bits, leave data fields as they were.
                regWrtOut <= 1'b0;
                haltOut   <= 1'b0;
                err       <= 1'b0;
            end else begin
                aluOut       <= aluResult;
                setValOut    <= setVal;
                nextPcOut    <= nextPc;
                regWrtSrcOut <= regWrtSrc;
                writeRegOut  <= writeReg;
                haltOut      <= halt;
                // An abandoned access must not write back garbage.
                regWrtOut    <= regWrt && !timeout;
                err          <= errIn || (memAck && memErr) || timeout;
                memDataOut   <= (memAck && !memWrt) ? memRdData : 16'd0;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

    logic        clk;
    logic        rst;
    logic [15:0] aluResult, storeData, setVal, nextPc, memRdData;
    logic        memEn, memWrt, regWrt, halt, errIn, memDone, memErr;
    logic [2:0]  regWrtSrc, writeReg;
    logic        memReq, memWr, stall, regWrtOut, haltOut, err;
    logic [15:0] memAddr, memWrData, memDataOut, aluOut, setValOut, nextPcOut;
    logic [2:0]  regWrtSrcOut, writeRegOut;

    int checks = 0;
    int errors = 0;

    memory_stage #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .aluResult(aluResult), .storeData(storeData), .setVal(setVal), .nextPc(nextPc),
        .memEn(memEn), .memWrt(memWrt), .regWrt(regWrt), .regWrtSrc(regWrtSrc),
        .writeReg(writeReg), .halt(halt), .errIn(errIn),
        .memDone(memDone), .memErr(memErr), .memRdData(memRdData),
        .memReq(memReq), .memWr(memWr), .memAddr(memAddr), .memWrData(memWrData),
        .stall(stall), .memDataOut(memDataOut), .aluOut(aluOut), .setValOut(setValOut),
        .nextPcOut(nextPcOut), .regWrtOut(regWrtOut), .regWrtSrcOut(regWrtSrcOut),
        .writeRegOut(writeRegOut), .haltOut(haltOut), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; registered outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearIn();
        aluResult = 16'h0; storeData = 16'h0; setVal = 16'h0; nextPc = 16'h0;
        memEn = 1'b0; memWrt = 1'b0; regWrt = 1'b0; regWrtSrc = 3'd0; writeReg = 3'd0;
        halt = 1'b0; errIn = 1'b0; memDone = 1'b0; memErr = 1'b0; memRdData = 16'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clearIn();
        memEn = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL reset_memReq got=%b exp=0", memReq); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (aluOut !== 16'h0) begin errors++; $display("FAIL reset_aluOut got=%h exp=0000", aluOut); end
        checks++; if (memDataOut !== 16'h0) begin errors++; $display("FAIL reset_memDataOut got=%h exp=0000", memDataOut); end
        checks++; if ({regWrtOut, haltOut, err} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {regWrtOut, haltOut, err}); end
        rst = 1'b0;
        clearIn();
        tick();
    endtask

    task automatic test_alu();
        clearIn();
        aluResult = 16'h1234; regWrt = 1'b1; writeReg = 3'd3;
        setVal = 16'h5555; nextPc = 16'h0102; regWrtSrc = 3'd2;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall got=%b exp=0", stall); end
        checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL alu_memReq got=%b exp=0", memReq); end
        tick();
        clearIn();
        checks++; if (aluOut !== 16'h1234) begin errors++; $display("FAIL alu_aluOut got=%h exp=1234", aluOut); end
        checks++; if (regWrtOut !== 1'b1) begin errors++; $display("FAIL alu_regWrtOut got=%b exp=1", regWrtOut); end
        checks++; if (writeRegOut !== 3'd3) begin errors++; $display("FAIL alu_writeRegOut got=%0d exp=3", writeRegOut); end
        checks++; if ({setValOut, nextPcOut} !== {16'h5555, 16'h0102}) begin errors++; $display("FAIL alu_passthru got=%h exp=55550102", {setValOut, nextPcOut}); end
        checks++; if (regWrtSrcOut !== 3'd2) begin errors++; $display("FAIL alu_regWrtSrcOut got=%0d exp=2", regWrtSrcOut); end
    endtask

    task automatic test_load_zero_wait();
        clearIn();
        aluResult = 16'h0040; memEn = 1'b1; regWrt = 1'b1; writeReg = 3'd5;
        memDone = 1'b1; memRdData = 16'hBEEF;
        #1;
        checks++; if ({memReq, memWr, stall} !== 3'b100) begin errors++; $display("FAIL ld0_handshake got=%b exp=100", {memReq, memWr, stall}); end
        checks++; if (memAddr !== 16'h0040) begin errors++; $display("FAIL ld0_memAddr got=%h exp=0040", memAddr); end
        tick();
        clearIn();
        checks++; if (memDataOut !== 16'hBEEF) begin errors++; $display("FAIL ld0_memDataOut got=%h exp=beef", memDataOut); end
        checks++; if ({regWrtOut, writeRegOut} !== {1'b1, 3'd5}) begin errors++; $display("FAIL ld0_regWrt got=%b exp=1101", {regWrtOut, writeRegOut}); end
    endtask

    task automatic test_load_wait3();
        int stallCycles = 0;
        int bubbleBad = 0;
        clearIn();
        aluResult = 16'h0080; memEn = 1'b1; regWrt = 1'b1; writeReg = 3'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (stall === 1'b1) stallCycles++;
            if (memReq !== 1'b1 || memAddr !== 16'h0080) bubbleBad++;
            tick();
            if (regWrtOut !== 1'b0) bubbleBad++;
        end
        memDone = 1'b1; memRdData = 16'hBEEF;
        #1;
        checks++; if ({memReq, stall} !== 2'b10) begin errors++; $display("FAIL ld3_done_cycle got=%b exp=10", {memReq, stall}); end
        tick();
        clearIn();
        checks++; if (stallCycles !== 3) begin errors++; $display("FAIL ld3_stall_cycles got=%0d exp=3", stallCycles); end
        checks++; if (bubbleBad !== 0) begin errors++; $display("FAIL ld3_req_or_bubble got=%0d bad exp=0", bubbleBad); end
        checks++; if (memDataOut !== 16'hBEEF) begin errors++; $display("FAIL ld3_memDataOut got=%h exp=beef", memDataOut); end
        checks++; if ({regWrtOut, aluOut} !== {1'b1, 16'h0080}) begin errors++; $display("FAIL ld3_capture got=%h exp=10080", {regWrtOut, aluOut}); end
    endtask

    task automatic test_store();
        clearIn();
        aluResult = 16'h0010; storeData = 16'hA5A5; memEn = 1'b1; memWrt = 1'b1;
        #1;
        checks++; if ({memReq, memWr, stall} !== 3'b111) begin errors++; $display("FAIL st_handshake got=%b exp=111", {memReq, memWr, stall}); end
        checks++; if (memWrData !== 16'hA5A5) begin errors++; $display("FAIL st_memWrData got=%h exp=a5a5", memWrData); end
        tick();
        // Bubble: data fields keep the previous load's values.
        checks++; if ({memDataOut, aluOut} !== {16'hBEEF, 16'h0080}) begin errors++; $display("FAIL st_bubble_hold got=%h exp=beef0080", {memDataOut, aluOut}); end
        memDone = 1'b1; memRdData = 16'hFFFF;
        tick();
        clearIn();
        checks++; if ({memDataOut, aluOut} !== {16'h0000, 16'h0010}) begin errors++; $display("FAIL st_capture got=%h exp=00000010", {memDataOut, aluOut}); end
        checks++; if (regWrtOut !== 1'b0) begin errors++; $display("FAIL st_regWrtOut got=%b exp=0", regWrtOut); end
    endtask

    task automatic test_timeout();
        int stallCycles = 0;
        clearIn();
        aluResult = 16'h0200; memEn = 1'b1; regWrt = 1'b1;
        for (int i = 0; i < 15; i++) begin
            #1;
            if (stall === 1'b1) stallCycles++;
            tick();
        end
        #1;
        checks++; if (stallCycles !== 15) begin errors++; $display("FAIL to_stall_cycles got=%0d exp=15", stallCycles); end
        checks++; if ({memReq, stall} !== 2'b10) begin errors++; $display("FAIL to_fire_cycle got=%b exp=10", {memReq, stall}); end
        tick();
        clearIn();
        #1;
        checks++; if ({err, regWrtOut} !== 2'b10) begin errors++; $display("FAIL to_err got=%b exp=10", {err, regWrtOut}); end
        checks++; if ({aluOut, memDataOut} !== {16'h0200, 16'h0000}) begin errors++; $display("FAIL to_data got=%h exp=02000000", {aluOut, memDataOut}); end
        checks++; if ({memReq, stall} !== 2'b00) begin errors++; $display("FAIL to_after got=%b exp=00", {memReq, stall}); end
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_idle_next got=%b exp=0", err); end
    endtask

    task automatic test_timeout_race();
        clearIn();
        aluResult = 16'h0220; memEn = 1'b1; regWrt = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        memDone = 1'b1; memRdData = 16'h1357;
        tick();
        clearIn();
        checks++; if ({err, regWrtOut} !== 2'b01) begin errors++; $display("FAIL race_flags got=%b exp=01", {err, regWrtOut}); end
        checks++; if (memDataOut !== 16'h1357) begin errors++; $display("FAIL race_memDataOut got=%h exp=1357", memDataOut); end
    endtask

    task automatic test_mem_err();
        clearIn();
        aluResult = 16'h0044; memEn = 1'b1; regWrt = 1'b1; memDone = 1'b1; memErr = 1'b1;
        tick();
        clearIn();
        checks++; if ({err, regWrtOut} !== 2'b11) begin errors++; $display("FAIL memerr_flags got=%b exp=11", {err, regWrtOut}); end
        // memDone/memErr without a request must be ignored.
        aluResult = 16'h0300; memDone = 1'b1; memErr = 1'b1; memRdData = 16'hDEAD;
        tick();
        clearIn();
        checks++; if ({err, memDataOut} !== {1'b0, 16'h0000}) begin errors++; $display("FAIL ignore_done got=%h exp=00000", {err, memDataOut}); end
    endtask

    task automatic test_rst_in_wait();
        clearIn();
        aluResult = 16'h0500; memEn = 1'b1; regWrt = 1'b1;
        tick(); tick();
        rst = 1'b1;
        #1;
        checks++; if ({memReq, stall} !== 2'b00) begin errors++; $display("FAIL rstw_comb got=%b exp=00", {memReq, stall}); end
        checks++; if ({aluOut, regWrtOut, err} !== 18'h0) begin errors++; $display("FAIL rstw_regs got=%h exp=0", {aluOut, regWrtOut, err}); end
        tick();
        rst = 1'b0;
        clearIn();
        memDone = 1'b1; memRdData = 16'h7777;
        #1;
        checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL rstw_discard got=%b exp=0", memReq); end
        tick();
        clearIn();
        checks++; if (memDataOut !== 16'h0000) begin errors++; $display("FAIL rstw_nodata got=%h exp=0000", memDataOut); end
    endtask

    task automatic test_halt();
        clearIn();
        memEn = 1'b1; halt = 1'b1; aluResult = 16'h0600;
        #1;
        checks++; if ({memReq, stall} !== 2'b00) begin errors++; $display("FAIL halt_noreq got=%b exp=00", {memReq, stall}); end
        tick();
        clearIn();
        checks++; if (haltOut !== 1'b1) begin errors++; $display("FAIL halt_out got=%b exp=1", haltOut); end
        tick();
        checks++; if (haltOut !== 1'b0) begin errors++; $display("FAIL halt_clear got=%b exp=0", haltOut); end
    endtask

    task automatic test_back_to_back();
        clearIn();
        aluResult = 16'h0400; memEn = 1'b1; regWrt = 1'b1;
        tick();
        memDone = 1'b1; memRdData = 16'h1111;
        tick();
        checks++; if (memDataOut !== 16'h1111) begin errors++; $display("FAIL b2b_first got=%h exp=1111", memDataOut); end
        aluResult = 16'h0402; memRdData = 16'h2222;
        #1;
        checks++; if ({memReq, stall, memAddr} !== {2'b10, 16'h0402}) begin errors++; $display("FAIL b2b_req got=%h exp=20402", {memReq, stall, memAddr}); end
        tick();
        clearIn();
        checks++; if ({memDataOut, aluOut} !== {16'h2222, 16'h0402}) begin errors++; $display("FAIL b2b_second got=%h exp=22220402", {memDataOut, aluOut}); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_zero_wait();
        test_load_wait3();
        test_store();
        test_timeout();
        test_timeout_race();
        test_mem_err();
        test_rst_in_wait();
        test_halt();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
